issue_queue: RTL and testbench

ISSUE_QUEUE -- requirements
Module: issue_queue

---
 rtl/issue_queue.sv | 140 ++++++++++++++
 tb/tb_issue_queue.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue.sv
// In-order issue queue between decode and execute, with a register
// scoreboard that holds the head back on RAW/WAW hazards.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   in_*            decode side: valid/ready, payload, rs1/rs2/rd, use flags, we
//   out_*           execute side: valid/ready and head entry fields
//   wb_valid/wb_rd  commit clears the pending bit of wb_rd
//   flush           discard all queued entries (scoreboard untouched)
//   count           current occupancy
//   hazard_stall    head present but blocked by the scoreboard
module issue_queue #(
   parameter int DEPTH     = 4,
   parameter int PAYLOAD_W = 160,
   parameter int NREG      = 32,
   localparam int RA_W     = $clog2(NREG),
   localparam int PW       = $clog2(DEPTH),
   localparam int CW       = PW + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [PAYLOAD_W-1:0] in_payload,
   input  logic [RA_W-1:0]      in_rs1,
   input  logic [RA_W-1:0]      in_rs2,
   input  logic                 in_use_rs1,
   input  logic                 in_use_rs2,
   input  logic [RA_W-1:0]      in_rd,
   input  logic                 in_we,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PAYLOAD_W-1:0] out_payload,
   output logic [RA_W-1:0]      out_rs1,
   output logic [RA_W-1:0]      out_rs2,
   output logic [RA_W-1:0]      out_rd,
   output logic                 out_we,
   input  logic                 wb_valid,
   input  logic [RA_W-1:0]      wb_rd,
   input  logic                 flush,
   output logic [CW-1:0]        count,
   output logic                 hazard_stall
);

   logic [PAYLOAD_W-1:0] pl_q  [DEPTH];
   logic [RA_W-1:0]      rs1_q [DEPTH];
   logic [RA_W-1:0]      rs2_q [DEPTH];
   logic [RA_W-1:0]      rd_q  [DEPTH];
   logic [DEPTH-1:0]     u1_q;
   logic [DEPTH-1:0]     u2_q;
   logic [DEPTH-1:0]     we_q;

   logic [PW-1:0]   head_q, head_d;
   logic [PW-1:0]   tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;
   logic [NREG-1:0] pend_q, pend_d;
   logic [NREG-1:0] pend_eff;
   logic [NREG-1:0] wb_mask;

   logic head_u1, head_u2;
   logic blocked;
   logic enq, iss;

   assign out_payload = pl_q[head_q];
   assign out_rs1     = rs1_q[head_q];
   assign out_rs2     = rs2_q[head_q];
   assign out_rd      = rd_q[head_q];
   assign out_we      = we_q[head_q];
   assign head_u1     = u1_q[head_q];
   assign head_u2     = u2_q[head_q];

   assign count        = count_q;
   assign in_ready     = (count_q < CW'(DEPTH));
   assign enq          = in_valid && in_ready && !flush;
   assign out_valid    = (count_q != '0) && !blocked && !flush;
   assign hazard_stall = (count_q != '0) && blocked && !flush;
   assign iss          = out_valid && out_ready;

   // A register retiring this cycle no longer blocks the head.
   always_comb begin
      wb_mask = '0;
      if (wb_valid) wb_mask[wb_rd] = 1'b1;
      pend_eff    = pend_q & ~wb_mask;
      pend_eff[0] = 1'b0;
   end

   always_comb begin
      blocked = (head_u1 && pend_eff[out_rs1])
             || (head_u2 && pend_eff[out_rs2])
             || (out_we && (out_rd != '0) && pend_eff[out_rd]);
   end

   // Set is applied after clear so an issuing writer wins.
   always_comb begin
      pend_d = pend_q & ~wb_mask;
      if (iss && out_we && (out_rd != '0)) pend_d[out_rd] = 1'b1;
      pend_d[0] = 1'b0;
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = tail_q;
         count_d = '0;
      end else begin
         if (enq) tail_d = tail_q + PW'(1);
         if (iss) head_d = head_q + PW'(1);
         count_d = count_q + CW'(enq) - CW'(iss);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         pend_q  <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         pend_q  <= pend_d;
      end
   end

   always_ff @(posedge clk) begin
      if (enq && !rst) begin
         pl_q[tail_q]  <= in_payload;
         rs1_q[tail_q] <= in_rs1;
         rs2_q[tail_q] <= in_rs2;
         rd_q[tail_q]  <= in_rd;
         u1_q[tail_q]  <= in_use_rs1;
         u2_q[tail_q]  <= in_use_rs2;
         we_q[tail_q]  <= in_we;
      end
   end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: vector table for fill, RAW, WAW,
// x0 and flush; hand sequences for streaming with wrap and reset.
module tb_issue_queue;

   localparam int PW = 160;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready;
   logic [PW-1:0] in_payload;
   logic [4:0]    in_rs1, in_rs2, in_rd;
   logic          in_use_rs1, in_use_rs2, in_we;
   logic          out_valid, out_ready;
   logic [PW-1:0] out_payload;
   logic [4:0]    out_rs1, out_rs2, out_rd;
   logic          out_we;
   logic          wb_valid;
   logic [4:0]    wb_rd;
   logic          flush;
   logic [2:0]    count;
   logic          hazard_stall;

   always #5 clk = ~clk;

   issue_queue dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_payload(in_payload),
      .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
      .in_rd(in_rd), .in_we(in_we),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_payload(out_payload),
      .out_rs1(out_rs1), .out_rs2(out_rs2),
      .out_rd(out_rd), .out_we(out_we),
      .wb_valid(wb_valid), .wb_rd(wb_rd),
      .flush(flush), .count(count),
      .hazard_stall(hazard_stall)
   );

   typedef struct {
      logic        iv;
      logic [15:0] pl;
      logic [4:0]  rs1;
      logic        u1;
      logic [4:0]  rs2;
      logic        u2;
      logic [4:0]  rd;
      logic        we;
      logic        ordy;
      logic        wbv;
      logic [4:0]  wbrd;
      logic        fl;
      logic        rs;
      logic [2:0]  cnt;
      logic        irdy;
      logic        ov;
      logic        hs;
      logic        cpl;
      logic [15:0] opl;
   } vec_t;

   int passed = 0;
   int total  = 0;
   vec_t tv[$];

   function automatic vec_t mk(
      logic iv, logic [15:0] pl,
      logic [4:0] rs1, logic u1,
      logic [4:0] rs2, logic u2,
      logic [4:0] rd, logic we, logic ordy,
      logic wbv, logic [4:0] wbrd,
      logic fl, logic rs,
      logic [2:0] cnt, logic irdy,
      logic ov, logic hs,
      logic cpl, logic [15:0] opl);
      vec_t v;
      v.iv = iv;     v.pl = pl;
      v.rs1 = rs1;   v.u1 = u1;
      v.rs2 = rs2;   v.u2 = u2;
      v.rd = rd;     v.we = we;
      v.ordy = ordy; v.wbv = wbv;
      v.wbrd = wbrd; v.fl = fl;
      v.rs = rs;     v.cnt = cnt;
      v.irdy = irdy; v.ov = ov;
      v.hs = hs;     v.cpl = cpl;
      v.opl = opl;
      return v;
   endfunction

   task automatic chk(string nm, logic [31:0] act,
                      logic [31:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
      else
         passed++;
   endtask

   task automatic run(string tag, vec_t v);
      @(negedge clk);
      rst        = v.rs;
      in_valid   = v.iv;
      in_payload = PW'(v.pl);
      in_rs1     = v.rs1;
      in_use_rs1 = v.u1;
      in_rs2     = v.rs2;
      in_use_rs2 = v.u2;
      in_rd      = v.rd;
      in_we      = v.we;
      out_ready  = v.ordy;
      wb_valid   = v.wbv;
      wb_rd      = v.wbrd;
      flush      = v.fl;
      #1;
      chk({tag, " count"}, 32'(count), 32'(v.cnt));
      chk({tag, " in_ready"}, 32'(in_ready), 32'(v.irdy));
      chk({tag, " out_valid"}, 32'(out_valid), 32'(v.ov));
      chk({tag, " hazard"}, 32'(hazard_stall), 32'(v.hs));
      if (v.cpl)
         chk({tag, " payload"}, out_payload[31:0], 32'(v.opl));
   endtask

   initial begin
      int sent, recv;
      rst = 1'b1;
      in_valid = 0; in_payload = '0;
      in_rs1 = 0; in_rs2 = 0; in_rd = 0;
      in_use_rs1 = 0; in_use_rs2 = 0; in_we = 0;
      out_ready = 0; wb_valid = 0; wb_rd = 0; flush = 0;
      repeat (2) @(posedge clk);

      // reset state, fill to full with out_ready low, drain in order
      tv.push_back(mk(0,0, 0,0,0,0,0,0,0,0,0,0,0, 0,1,0,0,0,0));
      tv.push_back(mk(1,1, 0,0,0,0,0,0,0,0,0,0,0, 0,1,0,0,0,0));
      tv.push_back(mk(1,2, 0,0,0,0,0,0,0,0,0,0,0, 1,1,1,0,1,1));
      tv.push_back(mk(1,3, 0,0,0,0,0,0,0,0,0,0,0, 2,1,1,0,1,1));
      tv.push_back(mk(1,4, 0,0,0,0,0,0,0,0,0,0,0, 3,1,1,0,1,1));
      tv.push_back(mk(1,5, 0,0,0,0,0,0,0,0,0,0,0, 4,0,1,0,1,1));
      tv.push_back(mk(0,0, 0,0,0,0,0,0,1,0,0,0,0, 4,0,1,0,1,1));
      tv.push_back(mk(0,0, 0,0,0,0,0,0,1,0,0,0,0, 3,1,1,0,1,2));
      tv.push_back(mk(0,0, 0,0,0,0,0,0,1,0,0,0,0, 2,1,1,0,1,3));
      tv.push_back(mk(0,0, 0,0,0,0,0,0,1,0,0,0,0, 1,1,1,0,1,4));
      tv.push_back(mk(0,0, 0,0,0,0,0,0,0,0,0,0,0, 0,1,0,0,0,0));
      // RAW on x5, writeback unblocks in the same cycle
      tv.push_back(mk(1,10,0,0,0,0,5,1,0,0,0,0,0, 0,1,0,0,0,0));
      tv.push_back(mk(1,11,5,1,0,0,6,1,1,0,0,0,0, 1,1,1,0,1,10));
      tv.push_back(mk(0,0, 0,0,0,0,0,0,1,0,0,0,0, 1,1,0,1,0,0));
      tv.push_back(mk(0,0, 0,0,0,0,0,0,0,1,5,0,0, 1,1,1,0,1,11));
      tv.push_back(mk(0,0, 0,0,0,0,0,0,1,0,0,0,0, 1,1,1,0,1,11));
      // WAW on x6, set beats clear, x0 ignored
      tv.push_back(mk(1,12,0,0,0,0,6,1,1,0,0,0,0, 0,1,0,0,0,0));
      tv.push_back(mk(1,13,0,1,0,0,0,1,1,0,0,0,0, 1,1,0,1,0,0));
      tv.push_back(mk(0,0, 0,0,0,0,0,0,1,1,6,0,0, 2,1,1,0,1,12));
      tv.push_back(mk(0,0, 0,0,0,0,0,0,1,0,0,0,0, 1,1,1,0,1,13));
      tv.push_back(mk(1,14,0,0,6,1,0,0,0,0,0,0,0, 0,1,0,0,0,0));
      tv.push_back(mk(0,0, 0,0,0,0,0,0,1,0,0,0,0, 1,1,0,1,0,0));
      tv.push_back(mk(0,0, 0,0,0,0,0,0,1,1,6,0,0, 1,1,1,0,1,14));
      // flush at count 3 with in_valid; x9 stays pending
      tv.push_back(mk(1,20,0,0,0,0,9,1,0,0,0,0,0, 0,1,0,0,0,0));
      tv.push_back(mk(1,21,0,0,0,0,0,0,1,0,0,0,0, 1,1,1,0,1,20));
      tv.push_back(mk(1,22,0,0,0,0,0,0,0,0,0,0,0, 1,1,1,0,1,21));
      tv.push_back(mk(1,23,0,0,0,0,0,0,0,0,0,0,0, 2,1,1,0,1,21));
      tv.push_back(mk(1,24,0,0,0,0,0,0,1,0,0,1,0, 3,1,0,0,0,0));
      tv.push_back(mk(0,0, 0,0,0,0,0,0,0,0,0,0,0, 0,1,0,0,0,0));
      tv.push_back(mk(1,25,9,1,0,0,0,0,0,0,0,0,0, 0,1,0,0,0,0));
      tv.push_back(mk(0,0, 0,0,0,0,0,0,1,0,0,0,0, 1,1,0,1,0,0));
      tv.push_back(mk(0,0, 0,0,0,0,0,0,1,1,9,0,0, 1,1,1,0,1,25));

      foreach (tv[i]) run($sformatf("v%0d", i), tv[i]);

      // streaming with out_ready toggling; pointers wrap several times
      sent = 0;
      recv = 0;
      for (int c = 0; c < 200 && recv < 20; c++) begin
         @(negedge clk);
         in_valid   = (sent < 20);
         in_payload = PW'(100 + sent);
         in_use_rs1 = 0; in_use_rs2 = 0; in_we = 0;
         out_ready  = c[0];
         #1;
         if (count > 3'd4) chk("stream count", 32'(count), 32'd4);
         if (in_valid && in_ready) sent++;
         if (out_valid && out_ready) begin
            chk($sformatf("stream item %0d", recv),
                out_payload[31:0], 32'(100 + recv));
            recv++;
         end
      end
      chk("stream received", 32'(recv), 32'd20);

      // reset in mid-operation with enqueue and writeback active
      run("r0", mk(1,30,0,0,0,0,3,1,0,0,0,0,0, 0,1,0,0,0,0));
      run("r1", mk(1,31,0,0,0,0,0,0,1,0,0,0,0, 1,1,1,0,1,30));
      run("r2", mk(1,32,0,0,0,0,0,0,0,0,0,0,0, 1,1,1,0,1,31));
      run("r3", mk(1,33,0,0,0,0,0,0,0,1,7,0,1, 2,1,1,0,1,31));
      run("r4", mk(1,34,3,1,0,0,0,0,0,0,0,0,0, 0,1,0,0,0,0));
      run("r5", mk(0,0, 0,0,0,0,0,0,0,0,0,0,0, 1,1,1,0,1,34));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
